// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and FSM states.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN  = 2'b00,
      WAIT = 2'b01,
      HALT = 2'b10
   } state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage register numbers in, controls out.
interface hazard_ctrl_if #(
   parameter int REG_W = 4,
   parameter int CNT_W = 16
);
   logic [REG_W-1:0] id_ra, id_rb;
   logic [REG_W-1:0] ex_ra, ex_rb, ex_rc;
   logic             ex_reg_write, ex_mem_to_reg;
   logic [REG_W-1:0] mem_rc;
   logic             mem_reg_write;
   logic [REG_W-1:0] wb_rc;
   logic             wb_reg_write;
   logic             branch_taken;
   logic             mem_req, mem_ready;

   logic [1:0]       fwd_a, fwd_b;
   logic             en_if, en_id, en_ex, en_mem, en_wb;
   logic             flush_id, flush_ex, flush_mem;
   logic             halted;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output id_ra, id_rb, ex_ra, ex_rb, ex_rc, ex_reg_write, ex_mem_to_reg,
             mem_rc, mem_reg_write, wb_rc, wb_reg_write, branch_taken, mem_req, mem_ready,
      input  fwd_a, fwd_b, en_if, en_id, en_ex, en_mem, en_wb,
             flush_id, flush_ex, flush_mem, halted, stall_cycles
   );

   modport slave (
      input  id_ra, id_rb, ex_ra, ex_rb, ex_rc, ex_reg_write, ex_mem_to_reg,
             mem_rc, mem_reg_write, wb_rc, wb_reg_write, branch_taken, mem_req, mem_ready,
      output fwd_a, fwd_b, en_if, en_id, en_ex, en_mem, en_wb,
             flush_id, flush_ex, flush_mem, halted, stall_cycles
   );
endinterface

// File: rtl/forward_unit.sv
// Forwarding select for one EX operand; the younger MEM result wins over WB.
module forward_unit
   import hazard_pkg::*;
#(
   parameter int REG_W = 4
) (
   input  logic [REG_W-1:0] exReg,
   input  logic [REG_W-1:0] memRc,
   input  logic             memRegWrite,
   input  logic [REG_W-1:0] wbRc,
   input  logic             wbRegWrite,
   output fwd_sel_t         fwdSel
);

   // NOTE: default first so every path assigns fwdSel and no latch is inferred.
   always_comb begin
      fwdSel = FWD_RF;
      if (memRegWrite && memRc == exReg)
         fwdSel = FWD_MEM;
      else if (wbRegWrite && wbRc == exReg)
         fwdSel = FWD_WB;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: forwarding, stall/flush control,
// memory-wait sequencing with timeout, and a saturating stall counter.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_W   = 4,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input logic          clk,
   input logic          rst,
   hazard_ctrl_if.slave bus
);

   localparam logic [1:0] S_RUN  = 2'(RUN);
   localparam logic [1:0] S_WAIT = 2'(WAIT);
   localparam logic [1:0] S_HALT = 2'(HALT);
   localparam int         WCNT_W = $clog2(TIMEOUT);

   logic [1:0]        state;
   logic [WCNT_W-1:0] waitCnt;
   logic              halted;
   logic [CNT_W-1:0]  stallCycles;

   fwd_sel_t fwdA, fwdB;
   logic     freeze, loadUse, stallNow;
   logic     enFront, enBack, flushId, flushEx, flushMem;

   forward_unit #(.REG_W(REG_W)) fwdUnitA (
      .exReg       (bus.ex_ra),
      .memRc       (bus.mem_rc),
      .memRegWrite (bus.mem_reg_write),
      .wbRc        (bus.wb_rc),
      .wbRegWrite  (bus.wb_reg_write),
      .fwdSel      (fwdA)
   );

   forward_unit #(.REG_W(REG_W)) fwdUnitB (
      .exReg       (bus.ex_rb),
      .memRc       (bus.mem_rc),
      .memRegWrite (bus.mem_reg_write),
      .wbRc        (bus.wb_rc),
      .wbRegWrite  (bus.wb_reg_write),
      .fwdSel      (fwdB)
   );

   assign freeze  = bus.mem_req && !bus.mem_ready;
   assign loadUse = bus.ex_mem_to_reg && bus.ex_reg_write &&
                    (bus.ex_rc == bus.id_ra || bus.ex_rc == bus.id_rb);

   // A taken branch squashes the dependent instruction, so its load-use is not a stall.
   assign stallNow = (state == S_HALT) || freeze || (loadUse && !bus.branch_taken);

   always_comb begin
      enFront  = 1'b1;
      enBack   = 1'b1;
      flushId  = 1'b0;
      flushEx  = 1'b0;
      flushMem = 1'b0;
      if (!rst) begin
         if (state == S_HALT || freeze) begin
            enFront = 1'b0;
            enBack  = 1'b0;
         end else if (bus.branch_taken) begin
            flushId  = 1'b1;
            flushEx  = 1'b1;
            flushMem = 1'b1;
         end else if (loadUse) begin
            enFront = 1'b0;
            flushEx = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_RUN;
         waitCnt     <= '0;
         halted      <= 1'b0;
         stallCycles <= '0;
      end else begin
         if (stallNow && stallCycles != '1)
            stallCycles <= stallCycles + CNT_W'(1);

         case (state)
            S_RUN: begin
               if (freeze) begin
                  state   <= S_WAIT;
                  waitCnt <= WCNT_W'(1);
               end
            end
            S_WAIT: begin
               // Ready or a withdrawn request both release the pipeline.
               if (bus.mem_ready || !bus.mem_req) begin
                  state   <= S_RUN;
                  waitCnt <= '0;
               end else if (waitCnt == WCNT_W'(TIMEOUT - 1)) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
               end else begin
                  waitCnt <= waitCnt + WCNT_W'(1);
               end
            end
            S_HALT: state <= S_HALT;
            default: state <= S_RUN;
         endcase
      end
   end

   assign bus.fwd_a        = rst ? 2'b00 : 2'(fwdA);
   assign bus.fwd_b        = rst ? 2'b00 : 2'(fwdB);
   assign bus.en_if        = enFront;
   assign bus.en_id        = enFront;
   assign bus.en_ex        = enBack;
   assign bus.en_mem       = enBack;
   assign bus.en_wb        = enBack;
   assign bus.flush_id     = flushId;
   assign bus.flush_ex     = flushEx;
   assign bus.flush_mem    = flushMem;
   assign bus.halted       = halted;
   assign bus.stall_cycles = stallCycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (default, short timeout, narrow counter)
// share one stimulus stream.
module tb_hazard_ctrl;

   logic       clk;
   logic       rst;
   logic [3:0] idRa, idRb, exRa, exRb, exRc, memRc, wbRc;
   logic       exRegWrite, exMemToReg, memRegWrite, wbRegWrite;
   logic       branchTaken, memReq, memReady;

   int assertCnt = 0;
   int failCnt   = 0;

   hazard_ctrl_if #(.REG_W(4), .CNT_W(16)) busA ();
   hazard_ctrl_if #(.REG_W(4), .CNT_W(16)) busT ();
   hazard_ctrl_if #(.REG_W(4), .CNT_W(4))  busS ();

   hazard_ctrl #(.REG_W(4), .TIMEOUT(16), .CNT_W(16)) dutA (.clk(clk), .rst(rst), .bus(busA));
   hazard_ctrl #(.REG_W(4), .TIMEOUT(4),  .CNT_W(16)) dutT (.clk(clk), .rst(rst), .bus(busT));
   hazard_ctrl #(.REG_W(4), .TIMEOUT(32), .CNT_W(4))  dutS (.clk(clk), .rst(rst), .bus(busS));

   assign {busA.id_ra, busT.id_ra, busS.id_ra} = {3{idRa}};
   assign {busA.id_rb, busT.id_rb, busS.id_rb} = {3{idRb}};
   assign {busA.ex_ra, busT.ex_ra, busS.ex_ra} = {3{exRa}};
   assign {busA.ex_rb, busT.ex_rb, busS.ex_rb} = {3{exRb}};
   assign {busA.ex_rc, busT.ex_rc, busS.ex_rc} = {3{exRc}};
   assign {busA.mem_rc, busT.mem_rc, busS.mem_rc} = {3{memRc}};
   assign {busA.wb_rc, busT.wb_rc, busS.wb_rc} = {3{wbRc}};
   assign {busA.ex_reg_write, busT.ex_reg_write, busS.ex_reg_write} = {3{exRegWrite}};
   assign {busA.ex_mem_to_reg, busT.ex_mem_to_reg, busS.ex_mem_to_reg} = {3{exMemToReg}};
   assign {busA.mem_reg_write, busT.mem_reg_write, busS.mem_reg_write} = {3{memRegWrite}};
   assign {busA.wb_reg_write, busT.wb_reg_write, busS.wb_reg_write} = {3{wbRegWrite}};
   assign {busA.branch_taken, busT.branch_taken, busS.branch_taken} = {3{branchTaken}};
   assign {busA.mem_req, busT.mem_req, busS.mem_req} = {3{memReq}};
   assign {busA.mem_ready, busT.mem_ready, busS.mem_ready} = {3{memReady}};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCnt++;
      assert (obs === exp) else begin
         failCnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      {idRa, idRb, exRa, exRb, exRc, memRc, wbRc} = '0;
      {exRegWrite, exMemToReg, memRegWrite, wbRegWrite} = '0;
      {branchTaken, memReq, memReady} = '0;
   endtask

   initial begin
      clearInputs();
      // Reset overrides a freeze, a branch and a forwarding match.
      rst = 1'b1;
      memReq = 1'b1; branchTaken = 1'b1; memRegWrite = 1'b1;
      #1;
      check("rst_en_if", busA.en_if, 1);
      check("rst_en_ex", busA.en_ex, 1);
      check("rst_flush_id", busA.flush_id, 0);
      check("rst_flush_ex", busA.flush_ex, 0);
      check("rst_fwd_a", busA.fwd_a, 2'b00);
      tick();
      check("rst_stall", busA.stall_cycles, 0);
      check("rst_halted", busA.halted, 0);
      check("rst_state", dutA.state, 2'b00);
      clearInputs();
      rst = 1'b0;
      tick();

      // Forwarding priority and register 0.
      exRa = 4'd3; memRc = 4'd3; memRegWrite = 1'b1; wbRc = 4'd3; wbRegWrite = 1'b1; exRb = 4'd5;
      #1;
      check("fwd_a_mem", busA.fwd_a, 2'b01);
      check("fwd_b_none", busA.fwd_b, 2'b00);
      memRegWrite = 1'b0;
      #1;
      check("fwd_a_wb", busA.fwd_a, 2'b10);
      exRb = 4'd3; memRegWrite = 1'b1;
      #1;
      check("fwd_b_mem", busA.fwd_b, 2'b01);
      exRa = 4'd0; wbRc = 4'd0; memRc = 4'd7;
      #1;
      check("fwd_a_r0_wb", busA.fwd_a, 2'b10);
      clearInputs();
      tick();

      // Load-use on id_rb.
      exRc = 4'd2; exMemToReg = 1'b1; exRegWrite = 1'b1; idRb = 4'd2; idRa = 4'd7;
      #1;
      check("lu_en_if", busA.en_if, 0);
      check("lu_en_id", busA.en_id, 0);
      check("lu_flush_ex", busA.flush_ex, 1);
      check("lu_flush_id", busA.flush_id, 0);
      check("lu_en_ex", busA.en_ex, 1);
      check("lu_en_wb", busA.en_wb, 1);
      check("lu_stall_pre", busA.stall_cycles, 0);
      tick();
      check("lu_stall_post", busA.stall_cycles, 1);
      idRb = 4'd9;
      #1;
      check("lu_clear_en_if", busA.en_if, 1);
      check("lu_clear_flush_ex", busA.flush_ex, 0);
      idRa = 4'd2; exRegWrite = 1'b0;
      #1;
      check("lu_nowrite_en_id", busA.en_id, 1);
      tick();
      check("lu_clear_stall", busA.stall_cycles, 1);

      // Branch beats a simultaneous load-use.
      exRegWrite = 1'b1; idRb = 4'd2; branchTaken = 1'b1;
      #1;
      check("br_flush_id", busA.flush_id, 1);
      check("br_flush_ex", busA.flush_ex, 1);
      check("br_flush_mem", busA.flush_mem, 1);
      check("br_en_if", busA.en_if, 1);
      check("br_en_id", busA.en_id, 1);
      tick();
      check("br_stall", busA.stall_cycles, 1);
      clearInputs();

      // Three-cycle memory wait then ready.
      memReq = 1'b1;
      #1;
      check("mw_c1_en_if", busA.en_if, 0);
      tick();
      check("mw_c2_en_mem", busA.en_mem, 0);
      check("mw_c2_state", dutA.state, 2'b01);
      tick();
      check("mw_c3_en_id", busA.en_id, 0);
      tick();
      memReady = 1'b1;
      #1;
      check("mw_ready_en_if", busA.en_if, 1);
      check("mw_ready_en_wb", busA.en_wb, 1);
      check("mw_stall", busA.stall_cycles, 4);
      tick();
      memReq = 1'b0; memReady = 1'b0;
      #1;
      check("mw_back_run", dutA.state, 2'b00);
      check("mw_stall_hold", busA.stall_cycles, 4);

      // Request withdrawn while waiting.
      memReq = 1'b1;
      tick();
      memReq = 1'b0;
      #1;
      check("wd_en_if", busA.en_if, 1);
      check("wd_in_wait", dutA.state, 2'b01);
      tick();
      check("wd_run", dutA.state, 2'b00);
      check("wd_stall", busA.stall_cycles, 5);

      // Timeout with TIMEOUT = 4.
      rst = 1'b1;
      tick();
      check("to_rst_stall", busT.stall_cycles, 0);
      rst = 1'b0; memReq = 1'b1; memReady = 1'b0;
      #1;
      check("to_c1_en_if", busT.en_if, 0);
      repeat (3) tick();
      check("to_e3_halted", busT.halted, 0);
      check("to_e3_stall", busT.stall_cycles, 3);
      tick();
      check("to_e4_halted", busT.halted, 1);
      check("to_e4_stall", busT.stall_cycles, 4);
      check("to_e4_en_ex", busT.en_ex, 0);
      check("to_default_not_halted", busA.halted, 0);
      memReq = 1'b0;
      #1;
      check("to_halt_en_wb", busT.en_wb, 0);
      check("to_default_en_wb", busA.en_wb, 1);
      tick();
      check("to_halt_stall", busT.stall_cycles, 5);
      check("to_sticky", busT.halted, 1);
      rst = 1'b1;
      #1;
      check("to_rst_en_if", busT.en_if, 1);
      tick();
      check("to_rst_halted", busT.halted, 0);
      check("to_rst_stall0", busT.stall_cycles, 0);
      check("to_rst_state", dutT.state, 2'b00);

      // Saturation with CNT_W = 4, TIMEOUT = 32.
      rst = 1'b0; memReq = 1'b1; memReady = 1'b0;
      repeat (15) tick();
      check("sat_e15", busS.stall_cycles, 15);
      repeat (5) tick();
      check("sat_e20", busS.stall_cycles, 15);
      check("sat_halted", busS.halted, 0);
      check("sat_en_if", busS.en_if, 0);

      clearInputs();
      rst = 1'b1;
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core: IF, ID, EX, MEM, WB.
- Produces forwarding selects for both ALU operands in EX.
- Produces per-buffer enables (stall) and flushes (clear).
- Sequences multi-cycle memory waits with a timeout, and keeps a saturating stall-cycle counter.

Parameters:
- REG_W, 4: register-number width.
- TIMEOUT, 16: max consecutive wait cycles before halting; must be ≥2.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_ra, id_rb  in  REG_W  source registers of the instruction in ID
- ex_ra, ex_rb  in  REG_W  source registers of the instruction in EX
- ex_rc  in  REG_W  destination register of the EX instruction
- ex_reg_write, ex_mem_to_reg  in  1  EX instruction writes a register / is a load
- mem_rc  in  REG_W  MEM-stage destination register
- mem_reg_write  in  1  MEM-stage register write
- wb_rc  in  REG_W  WB-stage destination register
- wb_reg_write  in  1  WB-stage register write
- branch_taken  in  1  taken branch resolved in MEM
- mem_req  in  1  MEM instruction accesses data memory
- mem_ready  in  1  data memory completes this cycle
- fwd_a, fwd_b  out  2  operand source select for EX
- en_if, en_id, en_ex, en_mem, en_wb  out  1  pipeline-register enables (1 = advance)
- flush_id, flush_ex, flush_mem  out  1  clear IF/ID, ID/EX, EX/MEM at the next edge
- halted  out  1  memory timeout; sticky until rst
- stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- While rst is high:
  - en_* = 1, flush_* = 0, fwd_* = 00.
  - The following register at the edge: state = RUN, wait_cnt = 0, halted = 0, stall_cycles = 0.
- Forwarding is combinational and valid in every state. For operand A:
  - mem_reg_write && mem_rc == ex_ra → 01.
  - else wb_reg_write && wb_rc == ex_ra → 10.
  - else 00.
  - MEM has priority over WB.
  - Operand B is identical using ex_rb.
  - Register 0 is ordinary and is forwarded like any other; 11 is never driven.
- freeze = mem_req && !mem_ready.
- Output priority, all combinational from state and inputs:
  1. HALT: all en_* = 0, flushes 0.
  2. freeze: all en_* = 0, flushes 0. branch_taken is ignored, since branches never access memory and the simultaneous case is a protocol violation.
  3. branch_taken: all en_* = 1; flush_id = flush_ex = flush_mem = 1.
  4. Load-use: ex_mem_to_reg && ex_reg_write && (ex_rc == id_ra || ex_rc == id_rb). Then en_if = en_id = 0, flush_ex = 1 (bubble), en_ex = en_mem = en_wb = 1.
  5. Otherwise: all en_* = 1, flushes 0.
- FSM states: RUN, WAIT, HALT.
  - RUN → WAIT when freeze; wait_cnt is set to 1.
  - WAIT with mem_ready → RUN; wait_cnt is cleared. Enables are already 1 in that cycle, so there is no extra bubble.
  - WAIT with freeze: wait_cnt increments. If wait_cnt == TIMEOUT-1, go to HALT and set halted = 1.
  - WAIT with mem_req dropped while not ready → RUN (request withdrawn).
  - HALT stays in HALT until rst.
- Timeout rule: halted rises TIMEOUT cycles after the first frozen cycle.
- stall_cycles increments by 1 on every cycle in which freeze, load-use stall, or HALT applies. It saturates at all-ones and does not wrap.
- Reset mid-WAIT or in HALT returns to RUN with counters cleared at that edge.

Decomposition:
- hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10.
  - state_t enum: RUN, WAIT, HALT.
- Sub-module forward_unit: combinational priority comparator for one operand, instantiated twice (a and b).
- FSM, counters and enable/flush logic live in hazard_ctrl.

Test Plan:
- Forwarding: ex_ra = 3, mem_rc = 3, mem_reg_write = 1, wb_rc = 3, wb_reg_write = 1 → fwd_a = 01. Drop mem_reg_write → fwd_a = 10. ex_rb = 5 with no match → fwd_b = 00.
- Load-use: ex_rc = 2, ex_mem_to_reg = ex_reg_write = 1, id_rb = 2 → en_if = en_id = 0, flush_ex = 1, stall_cycles 0 → 1 next edge. Next cycle with no match → all enables 1.
- Branch: branch_taken = 1 together with a load-use match → flush_id/ex/mem = 1, all en = 1, no stall count.
- Memory wait: mem_req = 1 with mem_ready low for 3 cycles, then high → enables 0 for 3 cycles and 1 on the ready cycle; stall_cycles = 3; state back to RUN.
- Timeout: TIMEOUT = 4, mem_req = 1, mem_ready = 0 held → halted = 1 after the 4th frozen cycle; enables stay 0. Then rst → halted = 0, stall_cycles = 0.
- Saturation: CNT_W = 4, hold freeze for 20 cycles with TIMEOUT = 32 → stall_cycles stays at 15.
